// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared 256x8 data memory port.
// One transaction per grant: IDLE (arbitrate, latch) -> ISSUE (drive memory) -> DONE (ack).
module dmem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic              gnt_q;       // 0 = cpu, 1 = dbg
  logic              last_grant;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              win;
  logic              in_issue;
  logic              in_done;

  always_comb begin
    win = ~cpu_req;
    if (cpu_req && dbg_req) begin
      win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_q      <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            gnt_q   <= win;
            we_q    <= win ? dbg_we    : cpu_we;
            addr_q  <= win ? dbg_addr  : cpu_addr;
            wdata_q <= win ? dbg_wdata : cpu_wdata;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          // Writes echo their own data back so both ack types carry a defined value.
          rdata_q <= we_q ? wdata_q : mem_dout;
          state   <= DONE;
        end
        DONE: begin
          last_grant <= gnt_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from state so an async reset drops mem_we and acks immediately.
  assign in_issue  = (state == ISSUE);
  assign in_done   = (state == DONE);

  assign mem_raddr = in_issue ? addr_q  : '0;
  assign mem_waddr = in_issue ? addr_q  : '0;
  assign mem_din   = in_issue ? wdata_q : '0;
  assign mem_we    = in_issue & we_q;

  assign cpu_ack   = in_done & ~gnt_q;
  assign dbg_ack   = in_done &  gnt_q;
  assign cpu_rdata = cpu_ack ? rdata_q : '0;
  assign dbg_rdata = dbg_ack ? rdata_q : '0;

  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected acks into a queue,
// a negedge monitor pops and checks port, data and cycle of every ack.
module tb_dmem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic       cpu_ack, dbg_ack, mem_we, busy;
  logic [7:0] cpu_rdata, dbg_rdata, mem_raddr, mem_waddr, mem_din, mem_dout;

  logic       f_cpu_req, f_cpu_we, f_dbg_req, f_dbg_we;
  logic [7:0] f_cpu_addr, f_cpu_wdata, f_dbg_addr, f_dbg_wdata;
  logic       f_cpu_ack, f_dbg_ack, f_mem_we, f_busy;
  logic [7:0] f_cpu_rdata, f_dbg_rdata, f_mem_raddr, f_mem_waddr, f_mem_din, f_mem_dout;

  logic [7:0] mem_r [256];
  logic [7:0] f_mem_r [256];

  typedef struct {
    bit         port;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(f_cpu_req), .cpu_we(f_cpu_we), .cpu_addr(f_cpu_addr), .cpu_wdata(f_cpu_wdata),
    .cpu_ack(f_cpu_ack), .cpu_rdata(f_cpu_rdata),
    .dbg_req(f_dbg_req), .dbg_we(f_dbg_we), .dbg_addr(f_dbg_addr), .dbg_wdata(f_dbg_wdata),
    .dbg_ack(f_dbg_ack), .dbg_rdata(f_dbg_rdata),
    .mem_raddr(f_mem_raddr), .mem_waddr(f_mem_waddr), .mem_we(f_mem_we),
    .mem_din(f_mem_din), .mem_dout(f_mem_dout), .busy(f_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: all locations start at 0x01, write on negedge, async read.
  initial begin
    for (int i = 0; i < 256; i++) mem_r[i] = 8'h01;
    forever begin
      @(negedge clk);
      if (mem_we) mem_r[mem_waddr] = mem_din;
    end
  end
  assign mem_dout = mem_r[mem_raddr];

  initial begin
    for (int i = 0; i < 256; i++) f_mem_r[i] = 8'h01;
    forever begin
      @(negedge clk);
      if (f_mem_we) f_mem_r[f_mem_waddr] = f_mem_din;
    end
  end
  assign f_mem_dout = f_mem_r[f_mem_raddr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_ack || dbg_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", {62'd0, cpu_ack, dbg_ack}, 64'd0);
        end else begin
          mon_e = q.pop_front();
          chk("ack_port", {62'd0, cpu_ack, dbg_ack}, mon_e.port ? 64'd1 : 64'd2);
          chk("ack_rdata", dbg_ack ? dbg_rdata : cpu_rdata, mon_e.data);
          chk("other_rdata", dbg_ack ? cpu_rdata : dbg_rdata, 64'd0);
          chk("ack_cycle", cyc, mon_e.cyc);
          chk("busy_at_ack", busy, 1);
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        mon_e = q.pop_front();
        chk("ack_timeout", 0, 1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {busy, cpu_ack, dbg_ack, mem_we, cpu_rdata, dbg_rdata,
             mem_raddr, mem_waddr, mem_din}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // One transaction; request fields are scrambled after the grant to prove they are latched.
  task automatic do_txn(input bit port, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp, input bit hold);
    if (port) begin
      dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    q.push_back('{port, exp, cyc + 2});
    step(1);
    chk("issue_we", mem_we, we);
    chk("issue_addr", {mem_raddr, mem_waddr}, {addr, addr});
    chk("issue_din", mem_din, wdata);
    chk("issue_busy", busy, 1);
    cpu_addr = ~addr; cpu_wdata = ~wdata; cpu_we = ~we;
    dbg_addr = ~addr; dbg_wdata = ~wdata; dbg_we = ~we;
    if (!hold) begin
      cpu_req = 1'b0; dbg_req = 1'b0;
    end
    step(1);
    cpu_req = 1'b0; dbg_req = 1'b0;
    step(1);
    chk("idle_after_txn", busy, 0);
  endtask

  initial begin
    int c0;
    int n_fc;
    int n_fd;
    rst_n = 1'b0;
    {cpu_req, cpu_we, dbg_req, dbg_we} = '0;
    {cpu_addr, cpu_wdata, dbg_addr, dbg_wdata} = '0;
    {f_cpu_req, f_cpu_we, f_dbg_req, f_dbg_we} = '0;
    {f_cpu_addr, f_cpu_wdata, f_dbg_addr, f_dbg_wdata} = '0;
    #1;
    chk_zero("reset_outputs");
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("busy_after_reset", busy, 0);

    // CPU write then read of the same location; a write ack echoes its data.
    do_txn(1'b0, 1'b1, 8'h1F, 8'h07, 8'h07, 1'b1);
    do_txn(1'b0, 1'b0, 8'h1F, 8'h00, 8'h07, 1'b1);

    // Single-cycle request pulse still completes.
    do_txn(1'b0, 1'b0, 8'h05, 8'h00, 8'h01, 1'b0);

    // Cross-port ordering at address 0x00.
    do_txn(1'b1, 1'b1, 8'h00, 8'h3C, 8'h3C, 1'b0);
    do_txn(1'b0, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b0);

    // Round-robin with both requests held: CPU, dbg, CPU, dbg.
    do_reset();
    cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h55;
    dbg_we = 1'b0; dbg_addr = 8'hFF; dbg_wdata = 8'h00;
    c0 = cyc;
    cpu_req = 1'b1; dbg_req = 1'b1;
    q.push_back('{1'b0, 8'h55, c0 + 2});
    q.push_back('{1'b1, 8'h01, c0 + 5});
    q.push_back('{1'b0, 8'h55, c0 + 8});
    q.push_back('{1'b1, 8'h01, c0 + 11});
    while (cyc < c0 + 11) step(1);
    cpu_req = 1'b0; dbg_req = 1'b0;
    step(2);
    chk("rr_drained", q.size(), 0);

    // Reset during ISSUE of a dbg write: write suppressed, no ack.
    dbg_we = 1'b1; dbg_addr = 8'h10; dbg_wdata = 8'hAA; dbg_req = 1'b1;
    step(1);
    dbg_req = 1'b0;
    chk("abort_issue_we", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("abort_outputs");
    step(1);
    rst_n = 1'b1;
    step(1);
    do_txn(1'b1, 1'b0, 8'h10, 8'h00, 8'h01, 1'b0);

    // Reset while an ack is being presented.
    cpu_we = 1'b0; cpu_addr = 8'h1F; cpu_req = 1'b1;
    step(1);
    cpu_req = 1'b0;
    step(1);
    chk("pre_reset_ack", {busy, cpu_ack}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk_zero("midrun_reset_outputs");
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("busy_after_midrun_reset", busy, 0);

    // Fixed priority: CPU takes every grant while both requests are held.
    f_cpu_we = 1'b0; f_cpu_addr = 8'h30;
    f_dbg_we = 1'b0; f_dbg_addr = 8'h40;
    f_cpu_req = 1'b1; f_dbg_req = 1'b1;
    n_fc = 0; n_fd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (f_cpu_ack) begin
        n_fc++;
        chk("fp_cpu_rdata", f_cpu_rdata, 8'h01);
      end
      if (f_dbg_ack) n_fd++;
    end
    f_cpu_req = 1'b0; f_dbg_req = 1'b0;
    chk("fp_cpu_grants", n_fc, 4);
    chk("fp_dbg_grants", n_fd, 0);

    step(3);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
